// File: rtl/main_function_param.sv
// Sequential shift-add multiplier computing a*b, a^2*b or a^3 on W-bit unsigned
// operands into a 3W-bit result, behind a start/busy/done handshake.
module main_function_param #(
  parameter int unsigned W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [W-1:0]     a_bi,
  input  logic [W-1:0]     b_bi,
  input  logic [1:0]       mode_bi,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [3*W-1:0]   result_bo
);

  localparam int unsigned RW = 3 * W;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {StIdle, StMul1, StMul2, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [1:0]      mode_q, mode_d;
  logic [RW-1:0]   mcand_q, mcand_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [RW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_pend_q, err_pend_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [RW-1:0]   result_q, result_d;
  logic [RW-1:0]   step_acc;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    mode_d     = mode_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    err_pend_d = err_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    result_d   = result_q;
    step_acc   = acc_q + (mplier_q[0] ? mcand_q : '0);

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          a_d      = a_bi;
          b_d      = b_bi;
          mode_d   = mode_bi;
          acc_d    = '0;
          cnt_d    = CW'(W - 1);
          busy_d   = 1'b1;
          mcand_d  = RW'(a_bi);
          mplier_d = (mode_bi == 2'b00) ? b_bi : a_bi;
          if (mode_bi == 2'b11) begin
            state_d    = StDone;
            err_pend_d = 1'b1;
          end else begin
            state_d    = StMul1;
            err_pend_d = 1'b0;
          end
        end
      end
      StMul1: begin
        acc_d    = step_acc;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          if (mode_q == 2'b00) begin
            state_d = StDone;
          end else begin
            // First product becomes the multiplicand of the second pass.
            state_d  = StMul2;
            mcand_d  = step_acc;
            acc_d    = '0;
            mplier_d = (mode_q == 2'b01) ? b_q : a_q;
            cnt_d    = CW'(W - 1);
          end
        end
      end
      StMul2: begin
        acc_d    = step_acc;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = StDone;
      end
      StDone: begin
        result_d = err_pend_q ? '0 : acc_q;
        err_d    = err_pend_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      mode_q     <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      err_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      mode_q     <= mode_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      err_pend_q <= err_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      result_q   <= result_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign result_bo = result_q;

endmodule

// File: tb/tb_main_function_param.sv
// Directed bench for main_function_param: one W=8 instance and one W=4 instance,
// all outputs sampled on the falling clock edge.
module tb_main_function_param;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8, start8, busy8, done8, err8;
  logic [7:0]  a8, b8;
  logic [1:0]  mode8;
  logic [23:0] res8;

  logic        rst4, start4, busy4, done4, err4;
  logic [3:0]  a4, b4;
  logic [1:0]  mode4;
  logic [11:0] res4;

  int n_vec = 0;
  int n_err = 0;

  main_function_param #(.W(8)) dut8 (
    .clk_i(clk), .rst_i(rst8), .a_bi(a8), .b_bi(b8), .mode_bi(mode8), .start_i(start8),
    .busy_o(busy8), .done_o(done8), .err_o(err8), .result_bo(res8)
  );

  main_function_param #(.W(4)) dut4 (
    .clk_i(clk), .rst_i(rst4), .a_bi(a4), .b_bi(b4), .mode_bi(mode4), .start_i(start4),
    .busy_o(busy4), .done_o(done4), .err_o(err4), .result_bo(res4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("miscompare on %s", tag);
    end
  endtask

  // Counts falling-edge samples with busy high; bounded so a stuck DUT cannot hang.
  task automatic wait_busy8(output int cyc, output bit saw_done);
    cyc = 0;
    saw_done = 1'b0;
    while (busy8 === 1'b1 && cyc < 200) begin
      if (done8 === 1'b1) saw_done = 1'b1;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic wait_busy4(output int cyc);
    cyc = 0;
    while (busy4 === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [1:0] mode, input logic [23:0] exp_res,
                      input logic exp_err, input int exp_len);
    int cyc;
    bit sd;
    @(negedge clk);
    a8 = a; b8 = b; mode8 = mode; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_busy8(cyc, sd);
    check({tag, "_len"}, 64'(cyc), 64'(exp_len));
    check({tag, "_early_done"}, 64'(sd), 64'd0);
    check({tag, "_done"}, 64'(done8), 64'd1);
    check({tag, "_res"}, 64'(res8), 64'(exp_res));
    check({tag, "_err"}, 64'(err8), 64'(exp_err));
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done8), 64'd0);
  endtask

  initial begin
    int cyc;
    bit sd;
    int dcount;
    rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; mode8 = '0;
    rst4 = 1'b1; start4 = 1'b0; a4 = '0; b4 = '0; mode4 = '0;
    repeat (2) @(negedge clk);
    rst8 = 1'b0; rst4 = 1'b0;
    check("rst_busy", 64'(busy8), 64'd0);
    check("rst_done", 64'(done8), 64'd0);
    check("rst_err", 64'(err8), 64'd0);
    check("rst_res", 64'(res8), 64'd0);

    run8("m01_123_45", 8'd123, 8'd45, 2'b01, 24'd680805, 1'b0, 17);
    run8("m00_123_45", 8'd123, 8'd45, 2'b00, 24'd5535, 1'b0, 9);
    run8("m10_255", 8'd255, 8'd0, 2'b10, 24'd16581375, 1'b0, 17);
    run8("m10_0", 8'd0, 8'd77, 2'b10, 24'd0, 1'b0, 17);
    run8("m11", 8'd7, 8'd9, 2'b11, 24'd0, 1'b1, 1);
    run8("m00_2_3", 8'd2, 8'd3, 2'b00, 24'd6, 1'b0, 9);

    // start held high; operands change while busy
    @(negedge clk);
    a8 = 8'd10; b8 = 8'd20; mode8 = 2'b00; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'd3; b8 = 8'd5;
    wait_busy8(cyc, sd);
    check("hold_first_len", 64'(cyc), 64'd9);
    check("hold_first_res", 64'(res8), 64'd200);
    check("hold_first_done", 64'(done8), 64'd1);
    @(negedge clk);
    check("hold_restart_busy", 64'(busy8), 64'd1);
    check("hold_restart_done", 64'(done8), 64'd0);
    start8 = 1'b0;
    wait_busy8(cyc, sd);
    check("hold_second_len", 64'(cyc), 64'd9);
    check("hold_second_res", 64'(res8), 64'd15);

    // reset in busy cycle 5 of a mode-01 operation
    @(negedge clk);
    a8 = 8'd123; b8 = 8'd45; mode8 = 2'b01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    check("abort_busy", 64'(busy8), 64'd0);
    check("abort_res", 64'(res8), 64'd0);
    check("abort_done", 64'(done8), 64'd0);
    dcount = 0;
    repeat (20) begin
      if (done8 === 1'b1) dcount++;
      @(negedge clk);
    end
    check("abort_no_done", 64'(dcount), 64'd0);
    run8("after_abort", 8'd5, 8'd7, 2'b01, 24'd175, 1'b0, 17);

    // W=4 instance: abort then full run
    @(negedge clk);
    a4 = 4'd9; b4 = 4'd11; mode4 = 2'b01; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (4) @(negedge clk);
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    check("w4_abort_busy", 64'(busy4), 64'd0);
    check("w4_abort_done", 64'(done4), 64'd0);
    a4 = 4'd15; b4 = 4'd15; mode4 = 2'b01; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    wait_busy4(cyc);
    check("w4_len", 64'(cyc), 64'd9);
    check("w4_done", 64'(done4), 64'd1);
    check("w4_res", 64'(res4), 64'd3375);
    check("w4_err", 64'(err4), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
